// File: rtl/decode_pkg.sv
// Shared constants for the register-file write-select decoder.
// Widths and reset value used by the decoder top and its bench.
package decode_pkg;

    localparam int unsigned SEL_W = 5;
    localparam int unsigned OUT_W = 32;

    localparam logic [OUT_W-1:0] DEC_RESET = 32'h0000_0000;

endpackage

// File: rtl/decode3to8.sv
// Gate-level 3-to-8 one-hot predecoder.
// Each output is a 3-input AND of true/complemented select bits.
module decode3to8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    logic [2:0] w_n;

    assign w_n = ~i_sel;

    assign o_onehot[0] = w_n[2]   & w_n[1]   & w_n[0];
    assign o_onehot[1] = w_n[2]   & w_n[1]   & i_sel[0];
    assign o_onehot[2] = w_n[2]   & i_sel[1] & w_n[0];
    assign o_onehot[3] = w_n[2]   & i_sel[1] & i_sel[0];
    assign o_onehot[4] = i_sel[2] & w_n[1]   & w_n[0];
    assign o_onehot[5] = i_sel[2] & w_n[1]   & i_sel[0];
    assign o_onehot[6] = i_sel[2] & i_sel[1] & w_n[0];
    assign o_onehot[7] = i_sel[2] & i_sel[1] & i_sel[0];

endmodule

// File: rtl/decode_5to32.sv
// Registered 5-to-32 one-hot write-select decoder with enable.
// Predecode high bits to 8 groups, low bits to 4 lines, AND matrix, flop.
module decode_5to32
    import decode_pkg::*;
(
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             enable,
    input  logic [SEL_W-1:0] select,
    output logic [OUT_W-1:0] result
);

    logic [7:0]       w_group;
    logic [3:0]       w_low;
    logic [1:0]       w_low_n;
    logic [OUT_W-1:0] w_dec;
    logic [OUT_W-1:0] r_result;

    decode3to8 u_pre_hi (
        .i_sel    (select[4:2]),
        .o_onehot (w_group)
    );

    assign w_low_n = ~select[1:0];

    assign w_low[0] = w_low_n[1] & w_low_n[0];
    assign w_low[1] = w_low_n[1] & select[0];
    assign w_low[2] = select[1]  & w_low_n[0];
    assign w_low[3] = select[1]  & select[0];

    // Enable is folded into every AND term so a disabled or unknown
    // select can never leave a stray bit set.
    for (genvar i = 0; i < OUT_W; i++) begin : g_and
        assign w_dec[i] = w_group[i/4] & w_low[i%4] & enable;
    end

    // Output register with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_result <= DEC_RESET;
        end else begin
            r_result <= w_dec;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_decode_5to32.sv
// Directed and random checks for the registered 5-to-32 decoder.
// Inputs change 1 time unit after each rising edge; result sampled there too.
module tb_decode_5to32;

    logic        clock;
    logic        ctrl_reset_n;
    logic        enable;
    logic [4:0]  select;
    logic [31:0] result;

    int n_vec;
    int n_err;

    decode_5to32 dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .enable       (enable),
        .select       (select),
        .result       (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        n_vec++;
        assert (result === exp) else begin
            n_err++;
            $error("FAIL %s: result=%h expected=%h", tag, result, exp);
        end
    endtask

    initial begin
        logic [31:0] exp;
        logic        r_n;
        logic        en;
        logic [4:0]  sel;
        int          pc;

        n_vec = 0;
        n_err = 0;
        ctrl_reset_n = 1'b0;
        enable = 1'b0;
        select = 5'd0;

        step(); chk("reset0", 32'h0000_0000);
        step(); chk("reset1", 32'h0000_0000);

        enable = 1'b1;
        select = 5'd7;
        step(); chk("rst_hold_a", 32'h0000_0000);
        step(); chk("rst_hold_b", 32'h0000_0000);
        ctrl_reset_n = 1'b1;
        step(); chk("rst_release", 32'h0000_0080);

        for (int i = 0; i < 32; i++) begin
            select = 5'(i);
            step();
            exp = 32'h1 << i;
            chk($sformatf("sweep%0d", i), exp);
        end

        select = 5'd12;
        enable = 1'b0;
        step(); chk("en_off", 32'h0000_0000);
        enable = 1'b1;
        step(); chk("en_on", 32'h0000_1000);

        enable = 1'b0;
        select = 5'bxxxxx;
        step(); chk("x_sel_dis", 32'h0000_0000);

        enable = 1'b1;
        select = 5'd3;
        step(); chk("stream_a", 32'h0000_0008);
        step(); chk("stream_b", 32'h0000_0008);
        ctrl_reset_n = 1'b0;
        step(); chk("mid_rst", 32'h0000_0000);
        ctrl_reset_n = 1'b1;
        step(); chk("mid_rel", 32'h0000_0008);

        select = 5'd30;
        step(); chk("b2b_30", 32'h4000_0000);
        select = 5'd1;
        step(); chk("b2b_1", 32'h0000_0002);
        select = 5'd16;
        step(); chk("b2b_16", 32'h0001_0000);

        for (int k = 0; k < 1000; k++) begin
            r_n = ($urandom_range(9, 0) != 0);
            en  = 1'($urandom_range(1, 0));
            sel = 5'($urandom_range(31, 0));
            ctrl_reset_n = r_n;
            enable = en;
            select = sel;
            step();
            if (!r_n) exp = 32'h0;
            else if (en) exp = 32'h1 << sel;
            else exp = 32'h0;
            chk($sformatf("rand%0d", k), exp);
            pc = $countones(result);
            n_vec++;
            assert (pc <= 1) else begin
                n_err++;
                $error("FAIL onehot%0d: popcount=%0d expected<=1", k, pc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
